s_box_sequential: RTL and testbench

- Iterative AES S-box engine for the subBytes stage.
- Consumes the GF(2^8) multiply (8x8 to 15-bit polynomial product) and modulo-0x11B reduction blocks.
- Computes the multiplicative inverse as x^254 by square-and-multiply, then applies the affine transform. With INV=1 it computes the inverse S-box instead.
- Produces one byte per transaction using a start/done handshake. It is the consumer of the multiplication/modulus pair.

---
 rtl/s_box_sequential.sv | 139 +++++++++++++
 tb/tb_s_box_sequential.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/s_box_sequential.sv
// s_box_sequential
//   Iterative AES S-box engine. The GF(2^8) inverse is computed as x^254 by
//   seven square-and-multiply steps using a combinational carry-less multiply
//   reduced modulo 0x11B. The affine transform is applied after inversion
//   (INV=0, forward S-box). The inverse affine transform is applied before
//   inversion (INV=1, inverse S-box).
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request, sampled only while busy=0
//   data_in   in   [7:0] input byte, captured on the accepting edge
//   busy      out  high while a transaction is in flight
//   done      out  one-cycle pulse when data_out is updated
//   data_out  out  [7:0] result byte, held until the next done
module s_box_sequential #(
  parameter int unsigned INV = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [7:0] AFF_C  = 8'h63;
  localparam logic [7:0] IAFF_D = 8'h05;

  state_t     state_q, state_d;
  logic [7:0] sq_q, sq_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] t;

  // Carry-less 8x8 product to 15 bits, then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    // Clear bits 14..8 from the top down.
    for (int unsigned k = 0; k < 7; k++) begin
      if (p[14-k]) p = p ^ (15'h011B << (6 - k));
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ AFF_C[i];
    end
    return b;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8] ^ IAFF_D[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    t       = gf_mul(sq_q, sq_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          sq_d    = (INV != 0) ? inv_affine(data_in) : data_in;
          acc_d   = 8'h01;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        // Step k multiplies in x^(2^k); after seven steps acc = x^254 = x^-1.
        sq_d  = t;
        acc_d = gf_mul(acc_q, t);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = FINAL;
      end
      FINAL: begin
        dout_d  = (INV != 0) ? acc_q : affine(acc_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_s_box_sequential.sv
// tb_s_box_sequential
//   Directed bench for s_box_sequential: a forward (INV=0) and an inverse
//   (INV=1) instance share clock and reset. Expected bytes come from the
//   standard AES S-box table below.
module tb_s_box_sequential;

  logic       clk;
  logic       rst;
  logic       start_f, start_i;
  logic [7:0] din_f, din_i;
  logic       busy_f, busy_i;
  logic       done_f, done_i;
  logic [7:0] dout_f, dout_i;

  int unsigned errors;
  int unsigned checks;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  s_box_sequential #(.INV(0)) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .start    (start_f),
    .data_in  (din_f),
    .busy     (busy_f),
    .done     (done_f),
    .data_out (dout_f)
  );

  s_box_sequential #(.INV(1)) u_inv (
    .clk      (clk),
    .rst      (rst),
    .start    (start_i),
    .data_in  (din_i),
    .busy     (busy_i),
    .done     (done_i),
    .data_out (dout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on both instances; data_in is scrambled right after the
  // accepting edge to show it is no longer observed.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ea, input logic [7:0] eb);
    int unsigned n;
    @(negedge clk);
    start_f = 1'b1; din_f = a;
    start_i = 1'b1; din_i = b;
    @(negedge clk);
    start_f = 1'b0; din_f = ~a;
    start_i = 1'b0; din_i = ~b;
    check("busy_after_accept", busy_f, 1);
    n = 0;
    while (!done_f && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 8);
    check("busy_at_done", busy_f, 0);
    check("fwd_out", dout_f, ea);
    check("inv_done", done_i, 1);
    check("inv_out", dout_i, eb);
    @(negedge clk);
    check("done_width", done_f, 0);
    check("fwd_hold", dout_f, ea);
  endtask

  initial begin
    logic [7:0] cap, nv;
    int unsigned ndone, last, n;

    errors = 0; checks = 0;
    rst = 1'b1;
    start_f = 1'b0; start_i = 1'b0;
    din_f = '0; din_i = '0;

    // Reset held: start must be ignored.
    @(negedge clk);
    start_f = 1'b1; din_f = 8'h53; start_i = 1'b1; din_i = 8'h53;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_f = 1'b0; start_i = 1'b0;
      check("rst_busy", busy_f, 0);
      check("rst_done", done_f, 0);
      check("rst_out", dout_f, 8'h00);
      check("rst_inv_out", dout_i, 8'h00);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy_f, 0);
    check("idle_done", done_f, 0);
    check("idle_out", dout_f, 8'h00);

    // Directed vectors, forward and inverse side by side.
    run_one(8'h00, 8'h63, 8'h63, 8'h00);
    run_one(8'h01, 8'h7C, 8'h7C, 8'h01);
    run_one(8'h53, 8'hED, 8'hED, 8'h53);
    run_one(8'hFF, 8'h16, 8'h16, 8'hFF);

    // start held high with data_in changing every cycle.
    @(negedge clk);
    start_f = 1'b1; din_f = 8'h53;
    cap = 8'h53; ndone = 0; last = 0;
    for (int unsigned k = 0; k < 30; k++) begin
      @(negedge clk);
      nv = 8'(k * 37 + 11);
      din_f = nv;
      if (done_f) begin
        ndone++;
        check("held_out", dout_f, SBOX[cap]);
        if (ndone > 1) check("held_period", k - last, 9);
        last = k;
        cap = nv;
      end
    end
    check("held_done_count", ndone, 3);
    start_f = 1'b0;
    n = 0;
    while (!done_f && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_tail_seen", (n < 20) ? 1 : 0, 1);
    check("held_tail_out", dout_f, SBOX[cap]);
    @(negedge clk);

    // Asynchronous reset four cycles into a transaction.
    run_one(8'h53, 8'hED, 8'hED, 8'h53);
    @(negedge clk);
    start_f = 1'b1; din_f = 8'hFF;
    @(negedge clk);
    start_f = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy_f, 0);
    check("abort_done", done_f, 0);
    check("abort_out", dout_f, 8'h00);
    check("abort_inv_out", dout_i, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_f) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_out", dout_f, 8'h00);
    run_one(8'h01, 8'h7C, 8'h7C, 8'h01);

    // Full sweep: forward against the table, inverse back to the original.
    for (int i = 0; i < 256; i++) begin
      run_one(8'(i), SBOX[i], SBOX[i], 8'(i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
